battle_ctrl_gen: RTL
====================

Name: battle_ctrl_gen

Overview:
- Parametrised game controller for the battleship design; successor to the single-mode turn FSM.
- Sequences ship-count selection, ship placement, alternating turns, shot validation/commit and end-of-game.
- Adds an internal turn timer, a PC retry limit, per-side hit counters with win detection, and a player-vs-player mode.
- Sits between the board/register datapath, the VGA/LED front-end and the PC shot generator.

Parameters:
SHIP_W, 3, width of ship-count fields
MAX_SHIPS, 5, upper clamp on selected ship count
CELL_W, 5, width of hit counters and total_cells
TURN_CYCLES, 750000000, human turn length in clk cycles (15 s at 50 MHz)
TMR_W, 30, timer width; must satisfy 2^TMR_W > TURN_CYCLES
PC_RETRY_MAX, 16, invalid PC shots allowed before the PC turn is forfeited

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
btn  in  1  debounced one-cycle confirm pulse
mode  in  1  0 = player vs PC, 1 = two players; sampled only in S_SEL
n_ships  in  SHIP_W  requested ship count
ship_placed  in  1  pulse: one ship written to the board
shot_valid  in  1  current target cell not yet fired on (board lookup, same cycle)
shot_hit  in  1  current target cell holds a ship
total_cells  in  CELL_W  ship cells per side, stable after placement
state_o  out  3  encoded state (package enum)
side_o  out  1  active side: 0 = P1, 1 = P2/PC
sel_en  out  1  ship-count selection active
place_en  out  1  placement register enable
turn_en  out  1  human turn active (cursor/input enable)
pc_req  out  1  one-cycle request to the PC shot generator
fire_o  out  1  one-cycle board commit strobe
timeout_o  out  1  one-cycle pulse when a human turn expires
ships_cfg  out  SHIP_W  latched, clamped ship count
hits0, hits1  out  CELL_W  hits scored by side 0 / side 1
game_over  out  1  game finished
winner  out  2  0 = none, 1 = P1, 2 = P2/PC

Behaviour:
- Reset (rst low, asynchronous): state S_SEL, side 0, all counters 0, ships_cfg 1, winner 0, all strobes 0. The state register, side, counters and winner all clear asynchronously, including mid-game.
- S_SEL: sel_en=1. On btn: latch mode; ships_cfg = n_ships clamped (0 -> 1, >MAX_SHIPS -> MAX_SHIPS); go to S_PLACE.
- S_PLACE: place_en=1. Each ship_placed increments place_cnt.
  - When place_cnt == ships_cfg: if mode=1 and side=0, set side=1, clear place_cnt and stay in S_PLACE.
  - Otherwise set side=0 and go to S_TURN.
  - In mode 0, only side 0 places.
- S_TURN, human side (side 0, or side 1 in mode 1): turn_en=1; timer increments each cycle.
  - btn -> S_CHECK.
  - Timer reaching TURN_CYCLES-1 without btn -> timeout_o pulse, flip side, clear timer, stay in S_TURN.
  - btn in that same cycle wins over the timeout.
- S_TURN, PC side (mode 0, side 1): pc_req=1 for exactly one cycle, then S_CHECK.
- S_CHECK (1 cycle):
  - shot_valid=1 -> S_COMMIT.
  - Human with an invalid shot -> back to S_TURN; the timer is not cleared.
  - PC with an invalid shot -> retry_cnt++ and back to S_TURN. When retry_cnt reaches PC_RETRY_MAX, clear retry_cnt, flip side, go to S_TURN.
- S_COMMIT (1 cycle): fire_o=1.
  - If shot_hit, increment hits of the current side, saturating at 2^CELL_W-1.
  - If the new hit count == total_cells -> S_OVER, winner = side+1.
  - Otherwise flip side, clear timer and retry_cnt, go to S_TURN.
- S_OVER: game_over=1; holds until reset. btn is ignored.
- Latency: btn to fire_o is 2 cycles (S_CHECK, then S_COMMIT). pc_req to fire_o is 2 cycles.
- Ignored inputs: ship_placed outside S_PLACE, and btn outside S_SEL/S_TURN.
- Illegal state encoding -> S_SEL.

Decomposition:
- Package battle_pkg: state enum (S_SEL, S_PLACE, S_TURN, S_CHECK, S_COMMIT, S_OVER), winner encodings, side constants.
- Sub-module turn_timer: loadable counter with TURN_CYCLES and TMR_W parameters, clear/enable inputs and a terminal-count pulse.

Test Plan:
- n_ships=0, btn -> ships_cfg=1. n_ships=7 with MAX_SHIPS=5 -> ships_cfg=5. Both end in S_PLACE.
- mode=1, ships_cfg=2: 2 ship_placed pulses -> side_o=1, still S_PLACE; 2 more -> S_TURN, side_o=0.
- TURN_CYCLES=8, no btn in S_TURN -> timeout_o on cycle 8, side_o=1; btn on the terminal cycle -> S_CHECK, no timeout_o.
- mode 0, PC side with shot_valid held 0, PC_RETRY_MAX=3 -> 3 pc_req pulses, then side_o=0, no fire_o.
- total_cells=2: P1 fires twice with shot_valid=1, shot_hit=1 (PC misses in between) -> hits0=2, game_over=1, winner=1, fire_o count 3 in total.
- rst pulled low in S_COMMIT -> next sampled state S_SEL, hits0=hits1=0, fire_o=0.

Source files
------------

// File: rtl/battle_pkg.sv
// battle_pkg
//   Shared types and constants for the battleship game controller:
//   FSM state encoding, winner codes, side codes and the ship-count clamp.
package battle_pkg;

  typedef enum logic [2:0] {
    S_SEL    = 3'd0,
    S_PLACE  = 3'd1,
    S_TURN   = 3'd2,
    S_CHECK  = 3'd3,
    S_COMMIT = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam logic SIDE_P1 = 1'b0;
  localparam logic SIDE_P2 = 1'b1;

  // A request of zero ships still yields a playable one-ship game.
  function automatic int clamp_ships(input int req, input int max_ships);
    if (req <= 0)             return 1;
    else if (req > max_ships) return max_ships;
    else                      return req;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// turn_timer
//   Human turn timer. Holds the number of cycles left in the turn and
//   counts down while enabled; tc pulses on the last cycle of the turn
//   and the counter reloads itself so the next turn starts full.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   clr  reload to a full turn
//   en   count this cycle
//   tc   terminal count (last enabled cycle of the turn)
module turn_timer #(
  parameter int TURN_CYCLES = 750000000,
  parameter int TMR_W       = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMR_W-1:0] LOAD = TMR_W'(TURN_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q;

  assign tc = en && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= LOAD;
    end else if (clr || tc) begin
      cnt_q <= LOAD;
    end else if (en) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/battle_ctrl_gen.sv
// battle_ctrl_gen
//   Game controller for the battleship design: ship-count selection,
//   placement, alternating turns (human or PC), shot check/commit, hit
//   counting with win detection and a per-turn timeout for humans.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   btn               confirm pulse (selection / fire)
//   mode              0 = vs PC, 1 = two players (latched in S_SEL)
//   n_ships           requested ship count
//   ship_placed       one ship written to the board
//   shot_valid        target cell not fired on yet
//   shot_hit          target cell holds a ship
//   total_cells       ship cells per side
//   state_o, side_o   current state and active side
//   sel_en, place_en  selection / placement enables
//   turn_en, pc_req   human turn active / one-cycle PC shot request
//   fire_o            one-cycle board commit strobe
//   timeout_o         one-cycle human turn expiry pulse
//   ships_cfg         clamped ship count
//   hits0, hits1      hits scored by side 0 / side 1
//   game_over, winner end-of-game flag and winner code
//
// state    | meaning
// S_SEL    | waiting for ship count and mode, btn confirms
// S_PLACE  | counting placed ships, P2 places too in two-player mode
// S_TURN   | human aims (timed) or PC is asked for a shot
// S_CHECK  | one cycle: accept or reject the target cell
// S_COMMIT | one cycle: fire strobe, hit count, win check
// S_OVER   | game finished, held until reset
module battle_ctrl_gen
  import battle_pkg::*;
#(
  parameter int SHIP_W       = 3,
  parameter int MAX_SHIPS    = 5,
  parameter int CELL_W       = 5,
  parameter int TURN_CYCLES  = 750000000,
  parameter int TMR_W        = 30,
  parameter int PC_RETRY_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic              mode,
  input  logic [SHIP_W-1:0] n_ships,
  input  logic              ship_placed,
  input  logic              shot_valid,
  input  logic              shot_hit,
  input  logic [CELL_W-1:0] total_cells,
  output logic [2:0]        state_o,
  output logic              side_o,
  output logic              sel_en,
  output logic              place_en,
  output logic              turn_en,
  output logic              pc_req,
  output logic              fire_o,
  output logic              timeout_o,
  output logic [SHIP_W-1:0] ships_cfg,
  output logic [CELL_W-1:0] hits0,
  output logic [CELL_W-1:0] hits1,
  output logic              game_over,
  output logic [1:0]        winner
);

  localparam int RTY_W = $clog2(PC_RETRY_MAX + 1);
  localparam logic [CELL_W-1:0] HIT_MAX = '1;

  state_t            state_q, nxt_state;
  logic              side_q, nxt_side;
  logic              mode_q, nxt_mode;
  logic [SHIP_W-1:0] place_q, nxt_place;
  logic [RTY_W-1:0]  retry_q, nxt_retry;
  logic [SHIP_W-1:0] nxt_cfg;
  logic [CELL_W-1:0] nxt_hits0, nxt_hits1, hit_cnt;
  logic [1:0]        nxt_winner;
  logic              tmo_now;
  logic              human;
  logic              tmr_en, tmr_clr, tmr_tc;

  assign human   = (side_q == SIDE_P1) || mode_q;
  assign state_o = state_q;
  assign side_o  = side_q;

  // The timer keeps running across a rejected human shot (S_CHECK back to
  // S_TURN) and is reloaded everywhere else outside the turn.
  assign tmr_en  = (state_q == S_TURN) && human;
  assign tmr_clr = !((state_q == S_TURN) || (state_q == S_CHECK));

  turn_timer #(
    .TURN_CYCLES(TURN_CYCLES),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .en (tmr_en),
    .tc (tmr_tc)
  );

  always_comb begin
    nxt_state  = state_q;
    nxt_side   = side_q;
    nxt_mode   = mode_q;
    nxt_place  = place_q;
    nxt_retry  = retry_q;
    nxt_cfg    = ships_cfg;
    nxt_hits0  = hits0;
    nxt_hits1  = hits1;
    nxt_winner = winner;
    hit_cnt    = '0;
    tmo_now    = 1'b0;
    case (state_q)
      S_SEL: begin
        if (btn) begin
          nxt_mode  = mode;
          nxt_cfg   = SHIP_W'(clamp_ships(int'(n_ships), MAX_SHIPS));
          nxt_place = '0;
          nxt_side  = SIDE_P1;
          nxt_state = S_PLACE;
        end
      end
      S_PLACE: begin
        if (ship_placed) begin
          if (place_q == ships_cfg - 1'b1) begin
            nxt_place = '0;
            if (mode_q && (side_q == SIDE_P1)) begin
              nxt_side = SIDE_P2;
            end else begin
              nxt_side  = SIDE_P1;
              nxt_state = S_TURN;
            end
          end else begin
            nxt_place = place_q + 1'b1;
          end
        end
      end
      S_TURN: begin
        if (!human) begin
          nxt_state = S_CHECK;
        end else if (btn) begin
          nxt_state = S_CHECK;
        end else if (tmr_tc) begin
          tmo_now  = 1'b1;
          nxt_side = ~side_q;
        end
      end
      S_CHECK: begin
        if (shot_valid) begin
          nxt_state = S_COMMIT;
        end else begin
          nxt_state = S_TURN;
          if (!human) begin
            if (retry_q == RTY_W'(PC_RETRY_MAX - 1)) begin
              nxt_retry = '0;
              nxt_side  = ~side_q;
            end else begin
              nxt_retry = retry_q + 1'b1;
            end
          end
        end
      end
      S_COMMIT: begin
        hit_cnt = side_q ? hits1 : hits0;
        if (shot_hit && (hit_cnt != HIT_MAX)) begin
          hit_cnt = hit_cnt + 1'b1;
        end
        if (side_q) nxt_hits1 = hit_cnt;
        else        nxt_hits0 = hit_cnt;
        if (hit_cnt == total_cells) begin
          nxt_state  = S_OVER;
          nxt_winner = side_q ? WIN_P2 : WIN_P1;
        end else begin
          nxt_side  = ~side_q;
          nxt_retry = '0;
          nxt_state = S_TURN;
        end
      end
      S_OVER: begin
      end
      default: begin
        nxt_state = S_SEL;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up
  // exactly with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_SEL;
      side_q    <= SIDE_P1;
      mode_q    <= 1'b0;
      place_q   <= '0;
      retry_q   <= '0;
      ships_cfg <= SHIP_W'(1);
      hits0     <= '0;
      hits1     <= '0;
      winner    <= WIN_NONE;
      sel_en    <= 1'b1;
      place_en  <= 1'b0;
      turn_en   <= 1'b0;
      pc_req    <= 1'b0;
      fire_o    <= 1'b0;
      timeout_o <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= nxt_state;
      side_q    <= nxt_side;
      mode_q    <= nxt_mode;
      place_q   <= nxt_place;
      retry_q   <= nxt_retry;
      ships_cfg <= nxt_cfg;
      hits0     <= nxt_hits0;
      hits1     <= nxt_hits1;
      winner    <= nxt_winner;
      sel_en    <= (nxt_state == S_SEL);
      place_en  <= (nxt_state == S_PLACE);
      turn_en   <= (nxt_state == S_TURN) && ((nxt_side == SIDE_P1) || nxt_mode);
      pc_req    <= (nxt_state == S_TURN) && (nxt_side == SIDE_P2) && !nxt_mode;
      fire_o    <= (nxt_state == S_COMMIT);
      timeout_o <= tmo_now;
      game_over <= (nxt_state == S_OVER);
    end
  end

endmodule
